board_tx: RTL and testbench

BOARD_TX -- requirements
Module: board_tx

---
 rtl/board_pkg.sv | 30 +++
 rtl/board_tx_tick_gen.sv | 50 +++++
 rtl/board_tx.sv | 130 +++++++++++++
 tb/tb_board_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared widths, frame payload and FSM encoding for the board transmitter.
package board_pkg;

  localparam int unsigned BOARD_W  = 32;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned FRAME_W  = BOARD_W + 1;
  localparam int unsigned BIT_W    = 6;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned LAST_BIT = FRAME_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  // Error flag goes out first, so it sits in the MSB of the frame.
  typedef struct packed {
    logic               err;
    logic [BOARD_W-1:0] board;
  } frame_t;

  // Maps a transmit position (0 = first bit on the wire) to a frame bit index.
  function automatic logic [BIT_W-1:0] frame_index(input logic [BIT_W-1:0] pos);
    return BIT_W'(LAST_BIT) - pos;
  endfunction

endpackage

// File: rtl/board_tx_tick_gen.sv
// Half-period divider: strobes every CLK_DIV enabled cycles and tracks ser_clk phase.
module tick_gen
  import board_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_c_o,
  output logic phase_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Terminal count of the current half-period; depends on registered state only.
  assign tick_c_o = (cnt_q == DIV_W'(CLK_DIV - 1));
  assign phase_o  = phase_q;

  // Next divider count and phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en_i) begin
      if (tick_c_o) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Divider registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/board_tx.sv
// Serialises a 33-bit {error, board} snapshot to a shift-register display, then latches it.
module board_tx
  import board_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic [BOARD_W-1:0] board_in,
  input  logic               error_in,
  input  logic               frame_req,
  output logic               busy,
  output logic               ser_data,
  output logic               ser_clk,
  output logic               ser_latch,
  output logic               frame_done
);

  tx_state_t          state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  frame_t             shadow_q, shadow_d;
  logic [FRAME_W-1:0] frame_bits;

  logic busy_q, busy_d;
  logic ser_data_q, ser_data_d;
  logic ser_clk_q, ser_clk_d;
  logic ser_latch_q, ser_latch_d;
  logic frame_done_q, frame_done_d;

  logic div_clr, div_en, div_tick, div_phase;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i    (clka),
    .rst_ni   (restart_n),
    .clr_i    (div_clr),
    .en_i     (div_en),
    .tick_c_o (div_tick),
    .phase_o  (div_phase)
  );

  // Next-state logic and the output values for the cycle after this edge.
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    shadow_d     = shadow_q;
    div_clr      = 1'b0;
    div_en       = 1'b0;
    busy_d       = 1'b0;
    ser_data_d   = 1'b0;
    ser_clk_d    = 1'b0;
    ser_latch_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_bits   = '0;

    unique case (state_q)
      IDLE: begin
        if (frame_req) begin
          shadow_d = '{err: error_in, board: board_in};
          bit_d    = '0;
          div_clr  = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        div_en = 1'b1;
        // A bit ends at the terminal count of its high half.
        if (div_tick && div_phase) begin
          if (bit_q == BIT_W'(LAST_BIT)) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      LATCH: begin
        div_en = 1'b1;
        if (div_tick) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    frame_bits   = shadow_d;
    busy_d       = (state_d != IDLE);
    ser_latch_d  = (state_d == LATCH);
    frame_done_d = (state_d == DONE);
    if (state_d == SHIFT) begin
      ser_data_d = frame_bits[frame_index(bit_d)];
      ser_clk_d  = div_clr ? 1'b0 : (div_phase ^ div_tick);
    end
  end

  // State, shadow and output registers with synchronous active-low reset.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state_q      <= IDLE;
      bit_q        <= '0;
      shadow_q     <= '0;
      busy_q       <= 1'b0;
      ser_data_q   <= 1'b0;
      ser_clk_q    <= 1'b0;
      ser_latch_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      shadow_q     <= shadow_d;
      busy_q       <= busy_d;
      ser_data_q   <= ser_data_d;
      ser_clk_q    <= ser_clk_d;
      ser_latch_q  <= ser_latch_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign ser_data   = ser_data_q;
  assign ser_clk    = ser_clk_q;
  assign ser_latch  = ser_latch_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_board_tx.sv
// Scoreboard bench for board_tx: stimulus queues expected frames, a monitor rebuilds them from the wire.
module tb_board_tx;

  logic        clka = 1'b0;
  logic        restart_n;
  logic [31:0] board_in;
  logic        error_in;
  logic        frame_req;
  logic        frame_req1;
  logic        busy, ser_data, ser_clk, ser_latch, frame_done;
  logic        busy1, ser_data1, ser_clk1, ser_latch1, frame_done1;

  always #5 clka = ~clka;

  board_tx #(.CLK_DIV(2)) dut (
    .clka       (clka),
    .restart_n  (restart_n),
    .board_in   (board_in),
    .error_in   (error_in),
    .frame_req  (frame_req),
    .busy       (busy),
    .ser_data   (ser_data),
    .ser_clk    (ser_clk),
    .ser_latch  (ser_latch),
    .frame_done (frame_done)
  );

  board_tx #(.CLK_DIV(1)) dut1 (
    .clka       (clka),
    .restart_n  (restart_n),
    .board_in   (board_in),
    .error_in   (error_in),
    .frame_req  (frame_req1),
    .busy       (busy1),
    .ser_data   (ser_data1),
    .ser_clk    (ser_clk1),
    .ser_latch  (ser_latch1),
    .frame_done (frame_done1)
  );

  typedef struct {
    logic [32:0] bits;
    int          gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic start_frame(input logic [31:0] b, input logic e);
    exp_t x;
    @(negedge clka);
    board_in  = b;
    error_in  = e;
    frame_req = 1'b1;
    x.bits = {e, b};
    x.gap  = 0;
    sb_q.push_back(x);
    @(negedge clka);
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clka);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_frame_done required=frame_done", name);
    end
  endtask

  // Monitor: rebuild each frame from ser_clk rises and compare at frame_done.
  initial begin
    int          cyc = 0;
    int          start = 0;
    int          last_done = 0;
    int          nbits = 0;
    int          nlatch = 0;
    int          viol = 0;
    logic [32:0] word = '0;
    logic        pclk = 1'b0;
    logic        pbusy = 1'b0;
    logic        pdata = 1'b0;
    exp_t        e;
    forever begin
      @(posedge clka);
      #1;
      cyc++;
      if (!restart_n) begin
        nbits  = 0;
        nlatch = 0;
        viol   = 0;
        word   = '0;
      end else begin
        if (busy && !pbusy) begin
          start  = cyc - 1;
          nbits  = 0;
          nlatch = 0;
          viol   = 0;
          word   = '0;
        end
        if (ser_clk && !pclk) begin
          word = {word[31:0], ser_data};
          nbits++;
        end
        if (ser_clk && pclk && (ser_data !== pdata)) viol++;
        if (ser_latch) nlatch++;
        if (frame_done) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=none", word);
          end else begin
            e = sb_q.pop_front();
            check("frame_bits", longint'(word), longint'(e.bits));
            check("bit_count", nbits, 33);
            check("latch_cycles", nlatch, 2);
            check("frame_len", cyc - start, 135);
            check("data_stable", viol, 0);
            if (e.gap != 0) check("done_gap", cyc - last_done, e.gap);
          end
          last_done = cyc;
        end
      end
      pclk  = ser_clk;
      pbusy = busy;
      pdata = ser_data;
    end
  end

  // Directed stimulus.
  initial begin
    exp_t        x;
    int          tog;
    logic [32:0] w1;

    restart_n  = 1'b0;
    board_in   = '0;
    error_in   = 1'b0;
    frame_req  = 1'b0;
    frame_req1 = 1'b0;
    repeat (3) @(negedge clka);
    check("rst_busy", busy, 0);
    check("rst_ser_clk", ser_clk, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_latch", ser_latch, 0);
    check("rst_done", frame_done, 0);
    restart_n = 1'b1;
    repeat (2) @(negedge clka);

    // Corner bits of the board, error clear.
    start_frame(32'h8000_0001, 1'b0);
    check("busy_first_cycle", busy, 1);
    check("first_bit", ser_data, 0);
    wait_done("basic");

    // Error bit only.
    start_frame(32'h0000_0000, 1'b1);
    wait_done("error_only");

    // Mid-frame input changes must not leak into the frame.
    start_frame(32'h0000_0000, 1'b0);
    repeat (20) @(negedge clka);
    board_in = 32'hFFFF_FFFF;
    error_in = 1'b1;
    wait_done("shadow");
    board_in = '0;
    error_in = 1'b0;

    // Mixed pattern.
    start_frame(32'hA5A5_3C3C, 1'b1);
    wait_done("pattern");

    // A request while busy is dropped, not queued.
    start_frame(32'h1357_9BDF, 1'b0);
    repeat (30) @(negedge clka);
    frame_req = 1'b1;
    @(negedge clka);
    frame_req = 1'b0;
    wait_done("ignore_req");
    repeat (3) @(negedge clka);
    check("no_queued_frame", busy, 0);

    // Held request: back-to-back frames 136 cycles apart.
    @(negedge clka);
    board_in  = 32'h1234_5678;
    error_in  = 1'b0;
    frame_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x.bits = {1'b0, 32'h1234_5678};
      x.gap  = (i == 0) ? 0 : 136;
      sb_q.push_back(x);
    end
    repeat (400) @(negedge clka);
    frame_req = 1'b0;
    wait_done("held_req");
    repeat (5) @(negedge clka);
    check("held_idle", busy, 0);
    check("held_sb_empty", sb_q.size(), 0);

    // Reset during bit 10, then a fresh frame from the error bit.
    @(negedge clka);
    board_in  = 32'hFFFF_FFFF;
    error_in  = 1'b0;
    frame_req = 1'b1;
    @(negedge clka);
    frame_req = 1'b0;
    repeat (41) @(negedge clka);
    check("pre_rst_busy", busy, 1);
    restart_n = 1'b0;
    @(negedge clka);
    restart_n = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ser_clk", ser_clk, 0);
    check("mid_rst_ser_data", ser_data, 0);
    @(negedge clka);
    check("post_rst_idle", busy, 0);
    start_frame(32'h0F0F_0000, 1'b1);
    check("restart_first_bit", ser_data, 1);
    wait_done("after_reset");

    // CLK_DIV=1 instance: ser_clk toggles each cycle, 68-cycle frame.
    @(negedge clka);
    board_in   = 32'hA5A5_3C3C;
    error_in   = 1'b1;
    frame_req1 = 1'b1;
    @(negedge clka);
    frame_req1 = 1'b0;
    tog = 0;
    w1  = '0;
    for (int k = 1; k <= 66; k++) begin
      if (ser_clk1 !== ((k % 2) == 0)) tog++;
      if (busy1 !== 1'b1) tog++;
      if ((k % 2) == 0) w1 = {w1[31:0], ser_data1};
      @(negedge clka);
    end
    check("div1_toggle", tog, 0);
    check("div1_bits", longint'(w1), longint'({1'b1, 32'hA5A5_3C3C}));
    check("div1_latch", ser_latch1, 1);
    @(negedge clka);
    check("div1_done_at_68", frame_done1, 1);
    @(negedge clka);
    check("div1_idle", busy1, 0);

    repeat (3) @(negedge clka);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
